// File: rtl/fir_4tap_pkg.sv
// Shared constants for the fir_2_4tap family: the forward filter taps
// y[n] = 4x[n] + 3x[n-1] - x[n-2] - 2x[n-3] and the default sample widths.
package fir_4tap_pkg;

    localparam int H0 = 4;
    localparam int H1 = 3;
    localparam int H2 = -1;
    localparam int H3 = -2;

    // H0 is a power of two, so dividing by it is an arithmetic right shift
    localparam int H0_SH = $clog2(H0);

    localparam int XW_DEF = 8;
    localparam int YW_DEF = 16;

endpackage

// File: rtl/fir_inv_sat.sv
// Combinational core of the inverse filter: residue, floor division by H0,
// remainder detection and saturation to the XW-bit output range.
module fir_inv_sat
    import fir_4tap_pkg::*;
#(
    parameter int XW = XW_DEF,
    parameter int YW = YW_DEF
) (
    input  logic [YW-1:0] yin,
    input  logic [XW-1:0] x1,
    input  logic [XW-1:0] x2,
    input  logic [XW-1:0] x3,
    output logic [XW-1:0] q,
    output logic          inexact,
    output logic          sat
);

    // Three guard bits cover the 3*x1 + x2 + 2*x3 correction without overflow
    localparam int RW = YW + 3;

    localparam logic signed [RW-1:0] C1   = RW'(H1);
    localparam logic signed [RW-1:0] C2   = RW'(H2);
    localparam logic signed [RW-1:0] C3   = RW'(H3);
    localparam logic signed [RW-1:0] XMAX = (RW'(1) <<< (XW - 1)) - RW'(1);
    localparam logic signed [RW-1:0] XMIN = ~XMAX;

    // Returns {saturated_flag, clamped_value}
    function automatic logic [XW:0] saturate(input logic signed [RW-1:0] v);
        if (v > XMAX)
            return {1'b1, XMAX[XW-1:0]};
        else if (v < XMIN)
            return {1'b1, XMIN[XW-1:0]};
        else
            return {1'b0, v[XW-1:0]};
    endfunction

    logic signed [RW-1:0] r;
    logic signed [RW-1:0] qf;
    logic        [XW:0]   sat_res;

    always_comb begin
        r = RW'($signed(yin))
          - C1 * RW'($signed(x1))
          - C2 * RW'($signed(x2))
          - C3 * RW'($signed(x3));
        qf      = r >>> H0_SH;
        sat_res = saturate(qf);
    end

    assign q       = sat_res[XW-1:0];
    assign sat     = sat_res[XW];
    assign inexact = |r[H0_SH-1:0];

endmodule

// File: rtl/fir_inv_4tap.sv
// Inverse of the fixed 4-tap forward filter: recovers x[n] from y[n] with
// one cycle of latency behind a single-register valid/ready output stage.
module fir_inv_4tap
    import fir_4tap_pkg::*;
#(
    parameter int XW = XW_DEF,
    parameter int YW = YW_DEF
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          Clr,
    input  logic [YW-1:0] Yin,
    input  logic          Yin_valid,
    output logic          Yin_ready,
    output logic [XW-1:0] Xout,
    output logic          Xout_valid,
    input  logic          Xout_ready,
    output logic          Err
);

    logic signed [XW-1:0] x1;
    logic signed [XW-1:0] x2;
    logic signed [XW-1:0] x3;
    logic                 vld_p1;
    logic                 err_p1;
    logic        [XW-1:0] q_p0;
    logic                 inexact_p0;
    logic                 sat_p0;
    logic                 accept;

    assign Yin_ready = !vld_p1 || Xout_ready;
    assign accept    = Yin_valid && Yin_ready;

    fir_inv_sat #(
        .XW (XW),
        .YW (YW)
    ) u_sat (
        .yin     (Yin),
        .x1      (x1),
        .x2      (x2),
        .x3      (x3),
        .q       (q_p0),
        .inexact (inexact_p0),
        .sat     (sat_p0)
    );

    // p0 -> p1: x1 doubles as the output register since both always hold the newest q
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            x1     <= '0;
            x2     <= '0;
            x3     <= '0;
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
        end else if (Clr) begin
            x1     <= '0;
            x2     <= '0;
            x3     <= '0;
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
        end else if (accept) begin
            x3     <= x2;
            x2     <= x1;
            x1     <= $signed(q_p0);
            vld_p1 <= 1'b1;
            if (inexact_p0 || sat_p0)
                err_p1 <= 1'b1;
        end else if (Xout_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign Xout       = x1;
    assign Xout_valid = vld_p1;
    assign Err        = err_p1;

endmodule

// File: tb/tb_fir_inv_4tap.sv
// Self-checking bench for fir_inv_4tap against an arithmetic inverse-filter
// model and a forward-filter stimulus generator.
module tb_fir_inv_4tap;

    logic               Clk;
    logic               Rst_n;
    logic               Clr;
    logic signed [15:0] Yin;
    logic               Yin_valid;
    logic               Yin_ready;
    logic signed [7:0]  Xout;
    logic               Xout_valid;
    logic               Xout_ready;
    logic               Err;

    int tests = 0;
    int fails = 0;

    // model state: previous recovered samples and sticky error
    int m1, m2, m3;
    bit merr;

    fir_inv_4tap #(.XW(8), .YW(16)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Clr        (Clr),
        .Yin        (Yin),
        .Yin_valid  (Yin_valid),
        .Yin_ready  (Yin_ready),
        .Xout       (Xout),
        .Xout_valid (Xout_valid),
        .Xout_ready (Xout_ready),
        .Err        (Err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic int floor_div4(input int r);
        if (r >= 0) return r / 4;
        return -((-r + 3) / 4);
    endfunction

    // Inverse model: solve y = 4x + 3x1 - x2 - 2x3 for x, clamp to int8
    function automatic int model_step(input int y);
        int r, q;
        r = y - 3 * m1 + m2 + 2 * m3;
        q = floor_div4(r);
        if (r % 4 != 0) merr = 1'b1;
        if (q > 127) begin q = 127; merr = 1'b1; end
        if (q < -128) begin q = -128; merr = 1'b1; end
        m3 = m2; m2 = m1; m1 = q;
        return q;
    endfunction

    function automatic int fwd(input int x0, input int x1, input int x2, input int x3);
        return 4 * x0 + 3 * x1 - x2 - 2 * x3;
    endfunction

    task automatic model_clear();
        m1 = 0; m2 = 0; m3 = 0; merr = 1'b0;
    endtask

    task automatic do_clr();
        Yin_valid = 1'b0;
        Clr = 1'b1;
        @(posedge Clk); #1;
        Clr = 1'b0;
        model_clear();
    endtask

    task automatic push(input int y);
        Yin = 16'(y);
        Yin_valid = 1'b1;
        @(posedge Clk); #1;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0; Clr = 1'b0; Yin = '0; Yin_valid = 1'b0; Xout_ready = 1'b1;
        #2;
        tests++;
        if (Xout !== 8'sd0 || Xout_valid !== 1'b0 || Err !== 1'b0 || Yin_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset Xout=%0d vld=%b err=%b rdy=%b expected 0/0/0/1", Xout, Xout_valid, Err, Yin_ready);
        end
        repeat (2) @(posedge Clk);
        #1 Rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_impulse();
        int ys[6] = '{4, 3, -1, -2, 0, 0};
        int xs[6] = '{1, 0, 0, 0, 0, 0};
        do_clr();
        for (int i = 0; i < 6; i++) begin
            push(ys[i]);
            tests++;
            if (int'(Xout) !== xs[i] || Xout_valid !== 1'b1 || Err !== 1'b0) begin
                fails++;
                $display("FAIL impulse[%0d] Xout=%0d vld=%b err=%b expected %0d/1/0", i, Xout, Xout_valid, Err, xs[i]);
            end
        end
        Yin_valid = 1'b0;
    endtask

    task automatic test_stream();
        do_clr();
        push(40);
        tests++;
        if (int'(Xout) !== 10 || Err !== 1'b0) begin
            fails++; $display("FAIL stream0 Xout=%0d err=%b expected 10/0", Xout, Err);
        end
        push(10);
        tests++;
        if (int'(Xout) !== -5 || Err !== 1'b0) begin
            fails++; $display("FAIL stream1 Xout=%0d err=%b expected -5/0", Xout, Err);
        end
        Yin_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int xs[200];
        int h1, h2, h3;
        for (int i = 0; i < 200; i++) xs[i] = $urandom_range(255) - 128;
        do_clr();
        h1 = 0; h2 = 0; h3 = 0;
        for (int i = 0; i < 200; i++) begin
            push(fwd(xs[i], h1, h2, h3));
            h3 = h2; h2 = h1; h1 = xs[i];
            tests++;
            if (int'(Xout) !== xs[i] || Xout_valid !== 1'b1 || Yin_ready !== 1'b1) begin
                fails++;
                $display("FAIL b2b[%0d] Xout=%0d vld=%b rdy=%b expected %0d/1/1", i, Xout, Xout_valid, Yin_ready, xs[i]);
            end
        end
        Yin_valid = 1'b0;
        tests++;
        if (Err !== 1'b0) begin
            fails++; $display("FAIL b2b_err Err=%b expected 0", Err);
        end
    endtask

    task automatic test_inexact_sat();
        do_clr();
        push(5);
        tests++;
        if (int'(Xout) !== 1 || Err !== 1'b1) begin
            fails++; $display("FAIL inexact Xout=%0d err=%b expected 1/1", Xout, Err);
        end
        do_clr();
        tests++;
        if (Err !== 1'b0) begin
            fails++; $display("FAIL clr_err Err=%b expected 0", Err);
        end
        push(1000);
        tests++;
        if (int'(Xout) !== 127 || Err !== 1'b1) begin
            fails++; $display("FAIL sat_hi Xout=%0d err=%b expected 127/1", Xout, Err);
        end
        do_clr();
        push(-1000);
        tests++;
        if (int'(Xout) !== -128 || Err !== 1'b1) begin
            fails++; $display("FAIL sat_lo Xout=%0d err=%b expected -128/1", Xout, Err);
        end
        Yin_valid = 1'b0;
    endtask

    task automatic test_random_y();
        int y, exp;
        do_clr();
        for (int i = 0; i < 100; i++) begin
            y = $urandom_range(4000) - 2000;
            exp = model_step(y);
            push(y);
            tests++;
            if (int'(Xout) !== exp || Err !== merr) begin
                fails++;
                $display("FAIL rand_y[%0d] y=%0d Xout=%0d err=%b expected %0d/%b", i, y, Xout, Err, exp, merr);
            end
        end
        Yin_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int xs[6];
        int ys[6];
        for (int i = 0; i < 6; i++) xs[i] = $urandom_range(255) - 128;
        for (int i = 0; i < 6; i++)
            ys[i] = fwd(xs[i], (i > 0) ? xs[i-1] : 0, (i > 1) ? xs[i-2] : 0, (i > 2) ? xs[i-3] : 0);
        do_clr();
        Xout_ready = 1'b0;
        push(ys[0]);
        Yin = 16'(ys[1]);
        for (int c = 0; c < 5; c++) begin
            tests++;
            if (Yin_ready !== 1'b0 || int'(Xout) !== xs[0] || Xout_valid !== 1'b1) begin
                fails++;
                $display("FAIL bp_hold[%0d] rdy=%b Xout=%0d vld=%b expected 0/%0d/1", c, Yin_ready, Xout, Xout_valid, xs[0]);
            end
            @(posedge Clk); #1;
        end
        Xout_ready = 1'b1;
        for (int i = 1; i < 6; i++) begin
            push(ys[i]);
            tests++;
            if (int'(Xout) !== xs[i] || Xout_valid !== 1'b1) begin
                fails++;
                $display("FAIL bp_release[%0d] Xout=%0d vld=%b expected %0d/1", i, Xout, Xout_valid, xs[i]);
            end
        end
        Yin_valid = 1'b0;
        @(posedge Clk); #1;
        tests++;
        if (Xout_valid !== 1'b0) begin
            fails++; $display("FAIL consume_only vld=%b expected 0", Xout_valid);
        end
    endtask

    task automatic test_midstream_reset();
        do_clr();
        push(41); push(-77); push(300);
        Yin_valid = 1'b0;
        #2 Rst_n = 1'b0;
        #1;
        tests++;
        if (Xout !== 8'sd0 || Xout_valid !== 1'b0 || Err !== 1'b0 || Yin_ready !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset Xout=%0d vld=%b err=%b rdy=%b expected 0/0/0/1", Xout, Xout_valid, Err, Yin_ready);
        end
        @(posedge Clk); #1 Rst_n = 1'b1;
        push(8);
        tests++;
        if (int'(Xout) !== 2 || Err !== 1'b0) begin
            fails++; $display("FAIL after_reset Xout=%0d err=%b expected 2/0", Xout, Err);
        end
        Yin_valid = 1'b0;
    endtask

    task automatic test_clr_drop();
        do_clr();
        push(21);
        Yin = 16'sd40;
        Clr = 1'b1;
        @(posedge Clk); #1;
        Clr = 1'b0;
        Yin_valid = 1'b0;
        tests++;
        if (Xout !== 8'sd0 || Xout_valid !== 1'b0 || Err !== 1'b0) begin
            fails++;
            $display("FAIL clr_drop Xout=%0d vld=%b err=%b expected 0/0/0", Xout, Xout_valid, Err);
        end
        push(8);
        tests++;
        if (int'(Xout) !== 2 || Err !== 1'b0) begin
            fails++; $display("FAIL clr_next Xout=%0d err=%b expected 2/0", Xout, Err);
        end
        Yin_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_impulse();
        test_stream();
        test_back_to_back();
        test_inexact_sat();
        test_random_y();
        test_backpressure();
        test_midstream_reset();
        test_clr_drop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fir_inv_4tap.md
FIR_INV_4TAP -- requirements
Module: fir_inv_4tap

Interface
REQ-001 Parameters SHALL be one per line: name, default, meaning.
- XW, 8, signed sample width of the recovered output.
- YW, 16, signed width of the filtered input.
REQ-002 Ports SHALL be one per line: name, direction, width, meaning.
- Clk, in, 1, the single clock; all state changes on rising edge.
- Rst_n, in, 1, asynchronous active-low reset.
- Clr, in, 1, synchronous clear of history, output register and Err.
- Yin, in, YW, signed filtered sample y[n].
- Yin_valid, in, 1, Yin holds a valid sample.
- Yin_ready, out, 1, block accepts Yin this cycle.
- Xout, out, XW, signed recovered sample x[n].
- Xout_valid, out, 1, Xout holds a valid sample.
- Xout_ready, in, 1, downstream accepts Xout this cycle.
- Err, out, 1, sticky flag: inexact division or saturation seen.

Function
REQ-003 The block SHALL invert the fixed forward filter y[n] = 4x[n] + 3x[n-1] - x[n-2] - 2x[n-3].
REQ-004 It SHALL keep history registers x1, x2, x3 (XW-bit signed) holding x[n-1], x[n-2], x[n-3].
REQ-005 On each accept (Yin_valid && Yin_ready), it SHALL form residue r = Yin - 3*x1 + x2 + 2*x3.
- r is computed at YW+3 bits signed with no intermediate overflow.
REQ-006 The recovered value SHALL be q = r >>> 2, an arithmetic shift that gives floor division.
REQ-007 If r[1:0] != 0, Err SHALL set on the accept edge.
REQ-008 If q lies outside [-2^(XW-1), 2^(XW-1)-1], it SHALL saturate to the nearest bound and Err SHALL set.
REQ-009 The saturated q SHALL be what is written both to Xout and into x1.
- The history shifts x3<=x2, x2<=x1, x1<=q on the same edge.
REQ-010 Latency SHALL be exactly one cycle: Xout_valid rises on the edge that accepts Yin.
REQ-011 Yin_ready SHALL equal !Xout_valid || Xout_ready (combinational, single output register).
REQ-012 With Xout_valid=1 and Xout_ready=0, Xout and the history SHALL hold unchanged.
REQ-013 When an accept and an output consume occur in the same cycle, the new sample SHALL replace the old with no bubble.
- Sustained throughput is one sample per clock.
REQ-014 When only a consume occurs, Xout_valid SHALL clear.
REQ-015 Err SHALL stay sticky until Clr or reset.
REQ-016 Clr SHALL take priority over a simultaneous accept.
- That sample is dropped.
- x1..x3, Xout, Xout_valid and Err all go to 0.
REQ-017 After reset or Clr, history SHALL be zero, so the first sample inverts against zero initial state.

Reset
REQ-018 Rst_n low SHALL asynchronously force x1=x2=x3=0, Xout=0, Xout_valid=0 and Err=0.
- Yin_ready is therefore 1.
REQ-019 Reset asserted mid-stream SHALL discard any in-flight sample.
- The first accept after deassertion is treated as n=0.

Structure
REQ-020 Coefficient constants SHALL live in shared package fir_4tap_pkg, for reuse by fir_2_4tap-family blocks.
- H0=4, H1=3, H2=-1, H3=-2.
- Default widths XW and YW.
REQ-021 A single sub-module, fir_inv_sat, SHALL hold the residue, shift, remainder check and saturation (purely combinational).
- The top level holds only the history, the output register and the handshake.

Verification
REQ-022 Impulse: Yin 4,3,-1,-2,0,0 back-to-back, Xout_ready=1 -> Xout 1,0,0,0,0,0 with Err=0.
REQ-023 Stream: Yin 40,10 -> Xout 10,-5 with Err=0.
- Also: the forward filter applied to 200 random x values, fed back-to-back -> the exact x sequence, 1 sample/clk.
REQ-024 Inexact and saturating inputs:
- First Yin=5 -> Xout=1, Err=1.
- After Clr, first Yin=1000 -> Xout=127, Err=1.
- After Clr, first Yin=-1000 -> Xout=-128.
REQ-025 Backpressure: Xout_ready=0 for 5 cycles with Yin_valid=1 -> Yin_ready=0, Xout stable, no sample lost.
- On release, the output sequence is unchanged.
REQ-026 Mid-stream events:
- Rst_n pulsed low after 3 samples -> outputs 0 immediately; next Yin=8 -> Xout=2.
- Clr asserted in the same cycle as an accept -> that sample is dropped.
